cim_sbox_arbiter: RTL and testbench

- Sequences and shares the compute-in-memory S-box macro (16 byte lanes, each addressed by a 3-bit DEMUX_ADD and a 6-bit RWL_DEC_ADD, returning data on an 8-bit RIO) between two requesters.
- Requester D is the AES round datapath: 16-byte SubBytes.
- Requester K is the key-expansion unit: 4-byte SubWord on lanes 0..3.
- Owns lookup timing, lane enables, forward/inverse bank select and round-robin fairness, so neither requester drives the macro directly.

---
 rtl/cim_pkg.sv | 31 +++
 rtl/cim_rr_arb2.sv | 32 +++
 rtl/cim_sbox_arbiter.sv | 170 +++++++++++++++++
 tb/tb_cim_sbox_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Purpose: shared types, widths and address mapping for the CIM S-box arbiter.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
// Contents: state_t (FSM states), owner_t (access owner), lane address
//           widths, K lane count, cim_map() index-to-macro-address mapping.
package cim_pkg;

  localparam int LANE_AW = 6;  // row address bits per lane (RWL_DEC_ADD)
  localparam int LANE_BW = 3;  // bank/column bits per lane (DEMUX_ADD)
  localparam int K_LANES = 4;  // SubWord uses lanes 0..3

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_D = 1'b0,
    OWN_K = 1'b1
  } owner_t;

  // Bank bit selects the inverse table; the top two index bits pick the
  // column group, the low six bits the row.
  function automatic logic [LANE_BW+LANE_AW-1:0] cim_map(input logic [7:0] idx,
                                                         input logic       inv);
    return {inv, idx[7:6], idx[5:0]};
  endfunction

endpackage

// File: rtl/cim_rr_arb2.sv
// Purpose: two-input round-robin arbiter (D vs K) with a registered priority pointer.
// Latency: grants are combinational from the requests; the pointer updates at the edge where i_upd is high.
// Backpressure: none; the caller only strobes i_upd when it actually accepts a grant.
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_req_d/i_req_k requests;
//        i_upd pointer update strobe; o_gnt_d/o_gnt_k one-hot grant (or none).
module cim_rr_arb2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req_d,
  input  logic i_req_k,
  input  logic i_upd,
  output logic o_gnt_d,
  output logic o_gnt_k
);

  // 1 = K has priority on a tie. Starts at K, flips to the loser on each grant.
  logic r_prio_k;

  always_comb begin
    o_gnt_k = i_req_k & (r_prio_k | ~i_req_d);
    o_gnt_d = i_req_d & ~o_gnt_k;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_prio_k <= 1'b1;
    end else if (i_upd && (o_gnt_d || o_gnt_k)) begin
      r_prio_k <= o_gnt_d;
    end
  end

endmodule

// File: rtl/cim_sbox_arbiter.sv
// Purpose: shares the CIM S-box macro between the AES datapath (16 lanes) and key expansion (lanes 0..3).
// Latency: REQ sampled at E0 -> GNT after E0, RD_EN after E0, VLD after E(1+RD_LAT); one access per RD_LAT+2 cycles.
// Backpressure: requesters hold REQ until GNT; no new grant while busy or while EN is low.
// Ports: CLK/RSTn (sync active-low); EN grant enable; D_*/K_* request, bank, address, grant,
//        valid and data per requester; DEMUX_ADD/RWL_DEC_ADD/RD_EN/LANE_EN/RIO macro interface; BSY access in flight.
module cim_sbox_arbiter
  import cim_pkg::*;
#(
  parameter int RD_LAT = 1,  // macro read latency, legal 1..4
  parameter int NLANE  = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     EN,
  input  logic                     D_REQ,
  input  logic                     D_INV,
  input  logic [NLANE*8-1:0]       D_ADDR,
  output logic                     D_GNT,
  output logic                     D_VLD,
  output logic [NLANE*8-1:0]       D_DATA,
  input  logic                     K_REQ,
  input  logic                     K_INV,
  input  logic [K_LANES*8-1:0]     K_ADDR,
  output logic                     K_GNT,
  output logic                     K_VLD,
  output logic [K_LANES*8-1:0]     K_DATA,
  output logic [NLANE*LANE_BW-1:0] DEMUX_ADD,
  output logic [NLANE*LANE_AW-1:0] RWL_DEC_ADD,
  output logic                     RD_EN,
  output logic [NLANE-1:0]         LANE_EN,
  input  logic [NLANE*8-1:0]       RIO,
  output logic                     BSY
);

  // WAIT is entered with RD_LAT-2 and left when the counter hits zero,
  // giving RD_LAT-1 wait cycles.
  localparam logic [1:0] WAIT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_t                     r_state;
  owner_t                     r_own;
  logic [1:0]                 r_wcnt;
  logic                       r_d_gnt;
  logic                       r_k_gnt;
  logic                       r_d_vld;
  logic                       r_k_vld;
  logic                       r_rd_en;
  logic                       r_bsy;
  logic [NLANE-1:0]           r_lane_en;
  logic [NLANE*LANE_BW-1:0]   r_demux;
  logic [NLANE*LANE_AW-1:0]   r_rwl;
  logic [NLANE*8-1:0]         r_d_data;
  logic [K_LANES*8-1:0]       r_k_data;

  logic                       w_req_d;
  logic                       w_req_k;
  logic                       w_take;
  logic                       w_gnt_d;
  logic                       w_gnt_k;
  logic                       w_sel_inv;
  logic [NLANE*8-1:0]         w_sel_addr;
  logic [NLANE-1:0]           w_lane_en;
  logic [NLANE*LANE_BW-1:0]   w_demux;
  logic [NLANE*LANE_AW-1:0]   w_rwl;

  assign w_req_d = EN & D_REQ;
  assign w_req_k = EN & K_REQ;
  assign w_take  = (r_state == ST_IDLE) & (w_req_d | w_req_k);

  cim_rr_arb2 u_arb (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_req_d (w_req_d),
    .i_req_k (w_req_k),
    .i_upd   (w_take),
    .o_gnt_d (w_gnt_d),
    .o_gnt_k (w_gnt_k)
  );

  // K indices sit in the lane 0..3 slots; the remaining lanes are masked below.
  assign w_sel_addr = w_gnt_k ? {K_ADDR, {((NLANE-K_LANES)*8){1'b0}}} : D_ADDR;
  assign w_sel_inv  = w_gnt_k ? K_INV : D_INV;
  assign w_lane_en  = w_gnt_k ? {{K_LANES{1'b1}}, {(NLANE-K_LANES){1'b0}}} : {NLANE{1'b1}};

  // Lane 0 is the most significant slot of every bus; disabled lanes get address 0.
  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    localparam int L = NLANE - 1 - i;
    logic [LANE_BW+LANE_AW-1:0] w_map;
    assign w_map = w_lane_en[L] ? cim_map(w_sel_addr[L*8 +: 8], w_sel_inv) : '0;
    assign w_demux[L*LANE_BW +: LANE_BW] = w_map[LANE_BW+LANE_AW-1:LANE_AW];
    assign w_rwl[L*LANE_AW +: LANE_AW]   = w_map[LANE_AW-1:0];
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= ST_IDLE;
      r_own     <= OWN_D;
      r_wcnt    <= '0;
      r_d_gnt   <= 1'b0;
      r_k_gnt   <= 1'b0;
      r_d_vld   <= 1'b0;
      r_k_vld   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_bsy     <= 1'b0;
      r_lane_en <= '0;
      r_demux   <= '0;
      r_rwl     <= '0;
      r_d_data  <= '0;
      r_k_data  <= '0;
    end else begin
      // Pulses default low; addresses hold until the next grant.
      r_d_gnt   <= 1'b0;
      r_k_gnt   <= 1'b0;
      r_d_vld   <= 1'b0;
      r_k_vld   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_lane_en <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_d_gnt   <= w_gnt_d;
            r_k_gnt   <= w_gnt_k;
            r_own     <= w_gnt_k ? OWN_K : OWN_D;
            r_rd_en   <= 1'b1;
            r_lane_en <= w_lane_en;
            r_demux   <= w_demux;
            r_rwl     <= w_rwl;
            r_bsy     <= 1'b1;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wcnt  <= WAIT_INIT;
          r_state <= (RD_LAT > 1) ? ST_WAIT : ST_CAPTURE;
        end
        ST_WAIT: begin
          if (r_wcnt == 2'd0) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        ST_CAPTURE: begin
          if (r_own == OWN_K) begin
            r_k_data <= RIO[NLANE*8-1 -: K_LANES*8];
            r_k_vld  <= 1'b1;
          end else begin
            r_d_data <= RIO;
            r_d_vld  <= 1'b1;
          end
          r_bsy   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign D_GNT       = r_d_gnt;
  assign K_GNT       = r_k_gnt;
  assign D_VLD       = r_d_vld;
  assign K_VLD       = r_k_vld;
  assign D_DATA      = r_d_data;
  assign K_DATA      = r_k_data;
  assign DEMUX_ADD   = r_demux;
  assign RWL_DEC_ADD = r_rwl;
  assign RD_EN       = r_rd_en;
  assign LANE_EN     = r_lane_en;
  assign BSY         = r_bsy;

endmodule

// File: tb/tb_cim_sbox_arbiter.sv
// Purpose: directed self-checking bench for cim_sbox_arbiter at RD_LAT=1 and RD_LAT=3.
// Latency: n/a (bench).
// Backpressure: n/a (bench). A behavioural S-box macro with matching latency sits behind each DUT.
module tb_cim_sbox_arbiter;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         d_req, d_inv, k_req, k_inv;
  logic [127:0] d_addr;
  logic [31:0]  k_addr;

  logic         d_gnt1, d_vld1, k_gnt1, k_vld1, rd_en1, bsy1;
  logic [127:0] d_data1, rio1;
  logic [31:0]  k_data1;
  logic [47:0]  dm1;
  logic [95:0]  rw1;
  logic [15:0]  le1;

  logic         d_gnt3, d_vld3, k_gnt3, k_vld3, rd_en3, bsy3;
  logic [127:0] d_data3, rio3;
  logic [31:0]  k_data3;
  logic [47:0]  dm3;
  logic [95:0]  rw3;
  logic [15:0]  le3;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ASC     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ASC_SB  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [31:0]  KW      = 32'h09cf4f3c;
  localparam logic [31:0]  KW_SB   = 32'h018a84eb;

  cim_sbox_arbiter #(.RD_LAT(1), .NLANE(16)) u_dut1 (
    .CLK(clk), .RSTn(rstn), .EN(en),
    .D_REQ(d_req), .D_INV(d_inv), .D_ADDR(d_addr), .D_GNT(d_gnt1), .D_VLD(d_vld1), .D_DATA(d_data1),
    .K_REQ(k_req), .K_INV(k_inv), .K_ADDR(k_addr), .K_GNT(k_gnt1), .K_VLD(k_vld1), .K_DATA(k_data1),
    .DEMUX_ADD(dm1), .RWL_DEC_ADD(rw1), .RD_EN(rd_en1), .LANE_EN(le1), .RIO(rio1), .BSY(bsy1)
  );

  cim_sbox_arbiter #(.RD_LAT(3), .NLANE(16)) u_dut3 (
    .CLK(clk), .RSTn(rstn), .EN(en),
    .D_REQ(d_req), .D_INV(d_inv), .D_ADDR(d_addr), .D_GNT(d_gnt3), .D_VLD(d_vld3), .D_DATA(d_data3),
    .K_REQ(k_req), .K_INV(k_inv), .K_ADDR(k_addr), .K_GNT(k_gnt3), .K_VLD(k_vld3), .K_DATA(k_data3),
    .DEMUX_ADD(dm3), .RWL_DEC_ADD(rw3), .RD_EN(rd_en3), .LANE_EN(le3), .RIO(rio3), .BSY(bsy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- S-box tables built from GF(2^8) arithmetic ----------------
  logic [7:0] fsb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int j = 1; j < 256; j++) begin
      if (gmul(a, 8'(j)) == 8'h01) r = 8'(j);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  initial begin
    logic [7:0] b;
    for (int v = 0; v < 256; v++) begin
      b = ginv(8'(v));
      fsb[v] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
      b = rotl(8'(v), 1) ^ rotl(8'(v), 3) ^ rotl(8'(v), 6) ^ 8'h05;
      isb[v] = ginv(b);
    end
  end

  // Behavioural macro: address registered while RD_EN is high, data appears RD_LAT cycles later.
  function automatic logic [127:0] macro_read(input logic [47:0] dm, input logic [95:0] rw,
                                              input logic [15:0] le);
    logic [127:0] r;
    logic [7:0]   idx;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      idx = {dm[(15-i)*3 +: 2], rw[(15-i)*6 +: 6]};
      if (le[15-i]) r[(15-i)*8 +: 8] = dm[(15-i)*3+2] ? isb[idx] : fsb[idx];
    end
    return r;
  endfunction

  logic [127:0] p1;
  logic [127:0] p3 [3];

  always @(posedge clk) begin
    p1    <= rd_en1 ? macro_read(dm1, rw1, le1) : '0;
    p3[0] <= rd_en3 ? macro_read(dm3, rw3, le3) : '0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign rio1 = p1;
  assign rio3 = p3[2];

  // ---------------- helpers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int vld_seen;
    rstn = 1'b0; en = 1'b0;
    d_req = 1'b0; d_inv = 1'b0; d_addr = '0;
    k_req = 1'b0; k_inv = 1'b0; k_addr = '0;
    tick; tick;

    // Reset state
    check("rst_pulses", {d_gnt1, d_vld1, k_gnt1, k_vld1, rd_en1, bsy1}, 0);
    check("rst_data", {d_data1, k_data1}, 0);
    check("rst_addr", {dm1, rw1, le1}, 0);

    rstn = 1'b1; en = 1'b1;
    tick;

    // D-only forward lookup, RD_LAT=1
    d_req = 1'b1; d_addr = ASC; d_inv = 1'b0;
    tick;
    check("d_gnt", {d_gnt1, k_gnt1}, 2'b10);
    check("d_issue", {rd_en1, bsy1, le1}, {2'b11, 16'hffff});
    check("d_lane1_addr", {dm1[44:42], rw1[89:84]}, {3'b000, 6'h01});
    d_req = 1'b0; d_addr = {16{8'hff}};  // changes after grant must not matter
    tick;
    check("d_capture_cycle", {d_gnt1, d_vld1, rd_en1}, 0);
    tick;
    check("d_vld", d_vld1, 1);
    check("d_data_fwd", d_data1, ASC_SB);
    tick;
    check("d_vld_one_cycle", {d_vld1, bsy1}, 0);

    // K-only SubWord
    k_req = 1'b1; k_addr = KW; k_inv = 1'b0;
    tick;
    check("k_gnt_issue", {k_gnt1, d_gnt1, rd_en1, le1}, {3'b101, 16'hf000});
    check("k_lane0_3_addr", {dm1[47:36], rw1[95:72]},
          {3'b000, 3'b011, 3'b001, 3'b000, 6'h09, 6'h0f, 6'h0f, 6'h3c});
    check("k_disabled_lanes_zero", {dm1[35:0], rw1[71:0]}, 0);
    k_req = 1'b0;
    tick; tick;
    check("k_vld_no_dvld", {k_vld1, d_vld1}, 2'b10);
    check("k_data", k_data1, KW_SB);
    check("d_data_held", d_data1, ASC_SB);

    // Inverse bank
    d_req = 1'b1; d_inv = 1'b1; d_addr = {16{8'h63}};
    tick;
    check("inv_demux", dm1, {16{3'b101}});
    check("inv_rwl", rw1, {16{6'h23}});
    d_req = 1'b0;
    tick; tick;
    check("inv_vld", d_vld1, 1);
    check("inv_data", d_data1, 0);
    check("k_data_held", k_data1, KW_SB);

    // Contention right after reset
    rstn = 1'b0;
    tick;
    check("rst2_clear", {d_data1, k_data1, bsy1, d_vld1}, 0);
    rstn = 1'b1; d_req = 1'b1; k_req = 1'b1; d_inv = 1'b0; d_addr = ASC; k_addr = KW;
    tick;
    check("tie_k_first", {d_gnt1, k_gnt1}, 2'b01);
    k_req = 1'b0;
    tick; tick;
    check("tie_k_vld", {k_vld1, d_gnt1}, 2'b10);
    tick;
    check("tie_d_after_kvld", {d_gnt1, k_vld1}, 2'b10);
    d_req = 1'b0;
    tick; tick;
    check("tie_d_vld", {d_vld1, d_data1}, {1'b1, ASC_SB});

    // Both held: grants alternate K, D, K, D every RD_LAT+2 cycles
    d_req = 1'b1; k_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick;
      check($sformatf("alt_grant_%0d", g), {d_gnt1, k_gnt1}, (g % 2 == 0) ? 2'b01 : 2'b10);
      if (g < 3) begin
        tick; tick;
      end
    end
    d_req = 1'b0; k_req = 1'b0;
    tick; tick; tick;

    // RD_LAT=3 build with EN toggling
    rstn = 1'b0;
    tick;
    rstn = 1'b1; en = 1'b0; d_req = 1'b1; d_addr = ASC; d_inv = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      check($sformatf("en_low_no_gnt_%0d", c), {d_gnt3, bsy3}, 0);
    end
    en = 1'b1;
    tick;
    check("en_rise_gnt", d_gnt3, 1);
    d_req = 1'b0; en = 1'b0;  // in-flight access must still finish
    tick;
    check("lat3_wait", {rd_en3, bsy3, d_vld3}, 3'b010);
    tick; tick;
    check("lat3_no_early_vld", d_vld3, 0);
    tick;
    check("lat3_vld", {d_vld3, d_data3}, {1'b1, ASC_SB});

    k_req = 1'b1; k_addr = KW; k_inv = 1'b0;
    tick;
    check("en_low_k_held_0", k_gnt3, 0);
    tick;
    check("en_low_k_held_1", k_gnt3, 0);
    en = 1'b1;
    tick;
    check("en_rise_k_gnt", k_gnt3, 1);
    k_req = 1'b0;
    tick;
    check("k_in_wait", {bsy3, rd_en3}, 2'b10);

    // Reset while in WAIT
    rstn = 1'b0;
    tick;
    check("rst_wait_outs", {bsy3, rd_en3, k_vld3, d_vld3, k_gnt3}, 0);
    rstn = 1'b1;
    vld_seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      vld_seen = vld_seen | int'(k_vld3) | int'(d_vld3);
    end
    check("rst_wait_no_vld", vld_seen, 0);
    check("rst_wait_kdata_clear", k_data3, 0);
    k_req = 1'b1;
    tick;
    check("post_rst_k_gnt", k_gnt3, 1);
    k_req = 1'b0;
    tick; tick; tick;
    check("post_rst_no_early_vld", k_vld3, 0);
    tick;
    check("post_rst_k_vld", {k_vld3, k_data3}, {1'b1, KW_SB});
    tick; tick; tick;

    // Withdrawn request: dropped before it could be granted
    en = 1'b0; d_req = 1'b1;
    tick;
    d_req = 1'b0; en = 1'b1;
    tick;
    check("withdraw_no_gnt_a", {d_gnt1, d_gnt3, k_gnt1, k_gnt3}, 0);
    tick;
    check("withdraw_no_gnt_b", {d_gnt1, d_gnt3, bsy1, bsy3}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
